// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and the
// register-file geometry defaults.
package reg_dump_reader_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Sweeps a wrapping range of register indices through one combinational
// read port and streams each word out on a valid/ready interface.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(NUM_REGS - 1);

  dump_state_t state, state_next;

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] cur_inc;

  logic accept_start;
  logic load_en;
  logic take;
  logic kill;
  logic done_next;

  // Index difference wraps naturally in ADDR_W bits; the extra bit holds N=NUM_REGS.
  assign span       = last_reg - first_reg;
  assign word_count = {1'b0, span} + CNT_ONE;
  assign cur_inc    = (cur == IDX_MAX) ? '0 : cur + 1'b1;

  assign rd_addr = cur;
  assign busy    = (state != IDLE);
  assign take    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    load_en      = 1'b0;
    kill         = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        // A start coinciding with the done pulse waits for the next IDLE cycle.
        if (start && !done) begin
          accept_start = 1'b1;
          state_next   = READ;
        end
      end
      READ: begin
        load_en = (!out_valid || out_ready) && (remaining != '0);
        if (load_en && (remaining == CNT_ONE)) state_next = DRAIN;
      end
      DRAIN: begin
        if (take) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      kill       = 1'b1;
      load_en    = 1'b0;
      done_next  = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (kill) begin
        out_valid <= 1'b0;
        remaining <= '0;
      end else if (accept_start) begin
        cur       <= first_reg;
        remaining <= word_count;
      end else if (load_en) begin
        out_data  <= rd_data;
        out_index <= cur;
        out_last  <= (remaining == CNT_ONE);
        out_valid <= 1'b1;
        cur       <= cur_inc;
        remaining <= remaining - CNT_ONE;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected words are queued when a sweep
// is started and compared as the DUT hands them off.
module tb_reg_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam bit [7:0] RDY_PAT = 8'b0001_0101;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] first_reg, last_reg, rd_addr, out_index;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_last, busy, done;

  logic [DW-1:0] rf [32];
  exp_t          q[$];

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, done_rel = -1, done_cnt = 0, acc_cnt = 0;
  int rdy_mode = 0, pi = 0;

  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic [AW-1:0] held_i;
  logic          held_l;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data = rf[rd_addr];

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else begin
      out_ready = RDY_PAT[pi % 8];
      pi++;
    end
  end

  // Monitor: scoreboard pops, hold-stability under back-pressure, done pulses.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, held_d);
        check("hold_index", 32'(out_index), 32'(held_i));
        check("hold_last", 32'(out_last), 32'(held_l));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_word", 32'(out_index), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q.pop_front();
          check("word_data", out_data, e.d);
          check("word_index", 32'(out_index), 32'(e.i));
          check("word_last", 32'(out_last), 32'(e.l));
        end
        acc_cnt++;
      end
      stall_prev = out_valid && !out_ready && !abort;
      held_d = out_data;
      held_i = out_index;
      held_l = out_last;
      if (done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] idx;
    exp_t e;
    idx = f;
    forever begin
      e.d = rf[idx];
      e.i = idx;
      e.l = (idx == l);
      q.push_back(e);
      if (idx == l) break;
      idx = AW'((int'(idx) + 1) % 32);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of cycle 1 of the sweep.
  task automatic start_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    start_cyc = cyc;
    push_exp(f, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_index"}, 32'(out_index), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_reg = '0; last_reg = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: basic sweep 0..3, latency and done timing
    d0 = done_cnt;
    start_sweep(5'd0, 5'd3);
    check("t1_busy_c1", 32'(busy), 32'd1);
    check("t1_valid_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_c2", 32'(out_valid), 32'd1);
    wait_idle(50);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_done_cycle", 32'(done_rel), 32'd6);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: wrapping range 30..1
    d0 = done_cnt; a0 = acc_cnt;
    start_sweep(5'd30, 5'd1);
    wait_idle(50);
    check("t2_handshakes", 32'(acc_cnt - a0), 32'd4);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3: single word, then start held through the done cycle
    rf[25] = 32'hFFFF_FFFF;
    d0 = done_cnt;
    start_sweep(5'd25, 5'd25);
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
    end
    check("t3_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    push_exp(5'd25, 5'd25);
    @(posedge clk); #1;
    check("t3_start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t3_start_next_idle", 32'(busy), 32'd1);
    start = 1'b0;
    wait_idle(50);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 4: full sweep with random data and back-pressure
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    d0 = done_cnt; a0 = acc_cnt;
    rdy_mode = 1;
    start_sweep(5'd0, 5'd31);
    wait_idle(400);
    rdy_mode = 0;
    check("t4_handshakes", 32'(acc_cnt - a0), 32'd32);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 5: abort after the second accepted word, then a fresh sweep
    d0 = done_cnt; a0 = acc_cnt;
    start_sweep(5'd4, 5'd13);
    for (int n = 0; n < 20 && (acc_cnt - a0) < 2; n++) begin
      @(posedge clk); #1;
    end
    check("t5_two_words", 32'(acc_cnt - a0 >= 2), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_valid_after_abort", 32'(out_valid), 32'd0);
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    a0 = acc_cnt;
    start_sweep(5'd10, 5'd12);
    wait_idle(50);
    check("t5_restart_words", 32'(acc_cnt - a0), 32'd3);
    check("t5_restart_done", 32'(done_cnt - d0), 32'd1);

    // 6: start pulsed while busy is ignored; reset mid-sweep drops everything
    d0 = done_cnt;
    start_sweep(5'd0, 5'd31);
    repeat (3) @(posedge clk);
    #1;
    first_reg = 5'd7; last_reg = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midreset");
    q.delete();
    @(posedge clk); #1;
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    a0 = acc_cnt;
    start_sweep(5'd5, 5'd6);
    wait_idle(50);
    check("t6_after_reset_words", 32'(acc_cnt - a0), 32'd2);
    check("t6_after_reset_done", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side sweep engine for the KGP-RISC register file.
- On a start command it walks a contiguous, wrapping range of register indices through one combinational register-file read port.
- Each word is captured and presented on a valid/ready output stream, tagged with its index and a last flag.
- Used for debug/LED/UART dumps of architectural state without stalling the core's write port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width in bits.
- NUM_REGS, 32, number of registers. Must equal 2**ADDR_W so that index wrap is natural overflow.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep. Sampled only in IDLE.
- abort  input  1  cancel the current sweep. Synchronous.
- first_reg  input  ADDR_W  first index of the range. Latched on an accepted start.
- last_reg  input  ADDR_W  last index of the range, inclusive. Latched on an accepted start.
- rd_addr  output  ADDR_W  address driven to the register-file read port.
- rd_data  input  DATA_W  combinational read data for rd_addr, valid in the same cycle.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  captured register value.
- out_index  output  ADDR_W  index of out_data.
- out_last  output  1  this word is the final word of the sweep.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last word has been accepted.

Behaviour:
- Reset values:
  - state=IDLE; cur=0; remaining=0.
  - rd_addr=0; out_valid=0; out_data=0; out_index=0; out_last=0.
  - busy=0; done=0.
  - Reset has priority over every other input, including mid-sweep; the sweep is dropped silently with no done pulse.
- Word count: N = ((last_reg - first_reg) mod NUM_REGS) + 1, computed in ADDR_W+1 bits.
  - first_reg == last_reg gives N=1.
  - first_reg = 30, last_reg = 1 gives N=4: indices 30, 31, 0, 1.
  - first_reg = 0, last_reg = 31 gives N=32.
- rd_addr is always driven from cur. cur advances by 1 modulo NUM_REGS.
- States:
  - IDLE: start=1 latches cur=first_reg and remaining=N, then goes to READ. start is ignored in every other state.
  - READ: load_en = (!out_valid || out_ready) && remaining != 0. On load_en, at the clock edge:
    - out_data <= rd_data; out_index <= cur; out_last <= (remaining == 1); out_valid <= 1.
    - cur <= cur + 1; remaining <= remaining - 1.
    - If remaining == 1, go to DRAIN.
    - If out_valid && out_ready && !load_en, clear out_valid.
  - DRAIN: when out_valid && out_ready, clear out_valid, pulse done for 1 cycle, go to IDLE.
- Throughput: one word per cycle while out_ready is held high. Back-pressure holds the output registers stable; out_data must not change while out_valid && !out_ready.
- Latency: start accepted at the edge ending cycle 0; the first word is captured at the edge ending cycle 1; out_valid=1 from cycle 2.
- A concurrent register-file write to the index being read in the same cycle: the captured value is the pre-write (combinational) value. No snapshot coherency is provided.
- abort in READ or DRAIN: next cycle state=IDLE, out_valid=0, no done pulse. abort in IDLE has no effect. reset takes precedence over abort.
- done and start in the same cycle: start is accepted on the following IDLE cycle only. No back-to-back start in the done cycle.

Decomposition:
- Shared package: the state encoding (IDLE, READ, DRAIN) and the DATA_W/ADDR_W defaults shared with the register file.
- No sub-module is needed. The output register stage may be written inline; an optional reg_stage_out sub-module is acceptable if one is reused elsewhere.

Test Plan:
- first=0, last=3, RF[i]=i*16, out_ready=1 -> words 0x0, 0x10, 0x20, 0x30 on cycles 2-5, indices 0-3, out_last on index 3, done pulse at cycle 6, busy low after.
- first=30, last=1 -> indices 30, 31, 0, 1 in order, out_last only on index 1, exactly 4 handshakes.
- first=last=25, RF[25]=0xFFFFFFFF -> single word 0xFFFFFFFF, out_last=1, done once.
- Full sweep 0..31 with out_ready toggling in a 1010 pattern and stalls of 3 cycles -> 32 words in order, no drop or duplicate, out_data stable during stalls.
- Abort after the 2nd accepted word -> out_valid low next cycle, no done pulse, a new start then sweeps correctly from its first_reg.
- Reset asserted mid-sweep and start pulsed while busy -> all outputs return to reset values, and the start pulsed while busy leaves first_reg/last_reg and cur unchanged.
